// File: rtl/mem_stream_reader_pkg.sv
// rtl/mem_stream_reader_pkg.sv - shared constants, FSM encoding and helpers for mem_stream_reader
package mem_stream_reader_pkg;

  localparam int MSR_ADDR_W_DEFAULT = 11;
  localparam int MSR_DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } msr_state_e;

  // Bytes issued but not yet accepted, treating a beat that transfers this cycle as accepted.
  function automatic logic [1:0] msr_outstanding(input logic       inflight,
                                                 input logic [1:0] count,
                                                 input logic       pop);
    return {1'b0, inflight} + count - {1'b0, pop};
  endfunction

endpackage

// File: rtl/mem_stream_fifo2.sv
// rtl/mem_stream_fifo2.sv - two-entry FIFO buffering read data ahead of the output stream
module mem_stream_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = slot_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - burst reader from a 1-cycle-latency memory port to a byte stream (MEM_STREAM_CSUM_EN adds csum)
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_W = MSR_ADDR_W_DEFAULT,
  parameter int DATA_W = MSR_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              mem_enb,
  output logic [ADDR_W-1:0] mem_addrb,
  input  logic [DATA_W-1:0] mem_doutb,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef MEM_STREAM_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  msr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;
  logic              issue;

  logic [DATA_W:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              head_last;
  logic [1:0]        outstanding;

  assign pop         = m_valid && m_ready;
  assign head_last   = fifo_head[DATA_W];
  assign outstanding = msr_outstanding(inflight_q, fifo_count, pop);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    issue           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = start_addr;
          rem_d  = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        // Full-without-pop already implies two outstanding; the guard keeps the FIFO safe by construction.
        if ((outstanding < 2'd2) && !(fifo_full && !pop)) begin
          issue  = 1'b1;
          addr_d = addr_q + ONE;
          rem_d  = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Read data lands one cycle after issue; the last flag travels with it.
  mem_stream_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data({inflight_last_q, mem_doutb}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_enb   = issue;
  assign mem_addrb = addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_last    = !fifo_empty && head_last;

`ifdef MEM_STREAM_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q + m_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - scoreboard bench for mem_stream_reader
module tb_mem_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] start_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic        mem_enb;
  logic [10:0] mem_addrb;
  logic [7:0]  mem_doutb;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
`ifdef MEM_STREAM_CSUM_EN
  logic [7:0]  csum;
`endif

  mem_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_enb   (mem_enb),
    .mem_addrb (mem_addrb),
    .mem_doutb (mem_doutb),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
`ifdef MEM_STREAM_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_enb) mem_doutb <= mem[mem_addrb];
  end

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  logic [10:0] addr_exp_q[$];
  int          xfer_cyc[$];
  int          beats = 0;
  int          cyc = 0;
  logic        ready_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) m_ready = ~m_ready;
      else m_ready = 1'b1;
    end
  end

  // Monitor: reference model of busy/done plus the scoreboard for addresses and beats.
  initial begin
    logic       busy_m, done_m, prev_valid, prev_xfer, xfer;
    logic [7:0] prev_data;
    logic [8:0] e;
    int         issued, accepted;
    busy_m = 0; done_m = 0; prev_valid = 0; prev_xfer = 0; prev_data = 0;
    issued = 0; accepted = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        addr_exp_q.delete();
        busy_m = 0; done_m = 0; prev_valid = 0; prev_xfer = 0;
        issued = 0; accepted = 0;
      end else begin
        xfer = m_valid && m_ready;
        chk("busy", busy, busy_m);
        chk("done", done, done_m);
        if (prev_valid && !prev_xfer) begin
          chk("valid_held", m_valid, 1);
          chk("data_stable", m_data, prev_data);
        end
        if (mem_enb) begin
          if (!busy_m) fail_now("mem_enb_outside_burst");
          chk("outstanding_lt2", (issued - accepted - (xfer ? 1 : 0)) < 2, 1);
          if (addr_exp_q.size() == 0) fail_now("unexpected_read");
          else chk("mem_addrb", mem_addrb, addr_exp_q.pop_front());
          issued++;
        end
        done_m = 0;
        if (xfer) begin
          beats++;
          accepted++;
          xfer_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e[7:0]);
            chk("m_last", m_last, e[8]);
            if (e[8]) begin
              busy_m = 0;
              done_m = 1;
            end
          end
        end
        if (start && !busy_m) begin
          if (length == 0) done_m = 1;
          else busy_m = 1;
        end
        prev_valid = m_valid;
        prev_xfer  = xfer;
        prev_data  = m_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] a, input logic [10:0] l);
    start_addr = a;
    length     = l;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic start_burst(input logic [10:0] a, input logic [10:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [10:0] ad;
      ad = a + 11'(i);
      addr_exp_q.push_back(ad);
      exp_q.push_back({(i == int'(l) - 1), mem[ad]});
    end
    pulse_start(a, l);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    if (!done) fail_now(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_mem_enb"}, mem_enb, 0);
    chk({name, "_mem_addrb"}, mem_addrb, 0);
    chk({name, "_m_valid"}, m_valid, 0);
    chk({name, "_m_data"}, m_data, 0);
    chk({name, "_m_last"}, m_last, 0);
`ifdef MEM_STREAM_CSUM_EN
    chk({name, "_csum"}, csum, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int sz;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    step();

    // Basic burst: latency, back-to-back beats, last flag, done
    mem[11'h010] = 8'hA1; mem[11'h011] = 8'hA2; mem[11'h012] = 8'hA3; mem[11'h013] = 8'hA4;
    start_burst(11'h010, 11'd4);
    chk("busy_after_start", busy, 1);
    chk("latency_c1", m_valid, 0);
    step();
    chk("latency_c2", m_valid, 0);
    step();
    chk("latency_c3", m_valid, 1);
    wait_done("done_timeout_burst4");
    sz = xfer_cyc.size();
    if (sz >= 4) chk("consecutive_beats", xfer_cyc[sz-1] - xfer_cyc[sz-4], 3);
    else fail_now("too_few_beats_burst4");
    step();

    // Address wrap
    mem[11'h7FE] = 8'h31; mem[11'h7FF] = 8'h32; mem[11'h000] = 8'h33;
    start_burst(11'h7FE, 11'd3);
    wait_done("done_timeout_wrap");
    step();

    // Backpressure toggling
    ready_mode = 1'b1;
    start_burst(11'h100, 11'd8);
    wait_done("done_timeout_toggle");
    step();
    ready_mode = 1'b0;
    step();

    // Zero length, then start while busy is ignored
    pulse_start(11'h200, 11'd0);
    chk("zero_len_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_len_m_valid", m_valid, 0);
      chk("zero_len_mem_enb", mem_enb, 0);
    end
    start_burst(11'h300, 11'd5);
    step();
    pulse_start(11'h400, 11'd3);
    wait_done("done_timeout_ignored");
    step();
    step();
    chk("ignored_start_idle", busy, 0);

    // Reset mid-burst after two beats
    base = beats;
    start_burst(11'h500, 11'd6);
    for (int i = 0; i < 100 && beats < base + 2; i++) step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("midreset_beats", beats - base, 2);
    start_burst(11'h600, 11'd3);
    wait_done("done_timeout_after_reset");
    step();

    // Checksum burst
    mem[11'h700] = 8'hFF; mem[11'h701] = 8'h02; mem[11'h702] = 8'h10;
    start_burst(11'h700, 11'd3);
    wait_done("done_timeout_csum");
`ifdef MEM_STREAM_CSUM_EN
    chk("csum", csum, 8'h11);
`endif
    step();
    step();

    chk("beats_left", exp_q.size(), 0);
    chk("reads_left", addr_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the memory address width and the length width.
REQ-002 Parameter DATA_W, default 8, SHALL set the byte width of memory read data and stream data.
REQ-003 clk  input  1  the single clock; all logic SHALL be on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first memory address of the burst, captured with start.
REQ-007 length  input  ADDR_W  number of bytes to read, captured with start; 0 is legal.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-009 done  output  1  one-cycle pulse when the burst completes.
REQ-010 mem_enb  output  1  read enable to the memory read port.
REQ-011 mem_addrb  output  ADDR_W  read address to the memory read port.
REQ-012 mem_doutb  input  DATA_W  memory read data, valid exactly 1 cycle after mem_enb high.
REQ-013 m_valid, m_data[DATA_W], m_last  output  stream valid, byte, last-byte flag.
REQ-014 m_ready  input  1  downstream accept; a beat transfers when m_valid && m_ready.

Function
REQ-015 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-016 IDLE -> READ on start with length != 0; IDLE -> IDLE with done pulsed the next cycle on start with length == 0, with no memory read and no beat.
REQ-017 In READ the block SHALL assert mem_enb only when issued-but-unaccepted bytes (in flight + buffered) < 2.
REQ-018 mem_addrb SHALL begin at start_addr and increment by 1 per issued read, modulo 2^ADDR_W (2047 -> 0).
REQ-019 READ -> DRAIN in the cycle the length-th read is issued.
REQ-020 Returned mem_doutb SHALL be captured into a 2-entry FIFO in the cycle after its read; a capture is never dropped.
REQ-021 m_valid SHALL equal FIFO not empty; m_data SHALL be the FIFO head; byte order SHALL equal address order.
REQ-022 m_last SHALL be high only on the length-th byte of the burst.
REQ-023 DRAIN -> IDLE, with done pulsed, in the cycle after the last beat transfers.
REQ-024 Throughput SHALL be 1 byte/cycle with m_ready held high; first m_valid SHALL occur 2 cycles after start.
REQ-025 m_valid, once high, SHALL not drop and m_data SHALL stay stable until the beat transfers.
REQ-026 start while busy SHALL be ignored.
REQ-027 mem_enb SHALL be low whenever the state is not READ.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, empty the FIFO, and drive busy, done, mem_enb, m_valid and m_last to 0 and mem_addrb and m_data to 0.
REQ-029 Reset mid-burst SHALL discard the burst; any read data returning after rst_n deasserts SHALL be ignored.

Configuration
REQ-030 With MEM_STREAM_CSUM_EN defined, the block SHALL add output csum[DATA_W], the modulo-2^DATA_W sum of all transferred bytes of the last burst, valid when done pulses and held until the next accepted start; it is cleared to 0 on reset and on accepted start.
REQ-031 Without MEM_STREAM_CSUM_EN, the csum port and its logic SHALL be absent.

Structure
REQ-032 The FSM state encoding and the default ADDR_W/DATA_W constants SHALL live in the shared SoC package.
REQ-033 The 2-entry FIFO SHALL be the sub-module mem_stream_fifo2 (push, pop, full, empty, count).

Verification
REQ-034 start_addr=0x010, length=4, m_ready=1, memory 0x010..0x013 = A1 A2 A3 A4 -> beats A1,A2,A3,A4 on consecutive cycles, m_last on A4, done 1 cycle after the A4 beat.
REQ-035 start_addr=0x7FE, length=3 -> reads at 0x7FE, 0x7FF, 0x000; 3 beats in that order.
REQ-036 length=8, m_ready toggling 1/0 each cycle -> all 8 bytes delivered once, in order, m_data stable while stalled, mem_enb never issues a 3rd outstanding read.
REQ-037 start with length=0 -> done pulses next cycle, mem_enb and m_valid stay 0; a second start during a busy burst is ignored.
REQ-038 rst_n pulsed low after 2 beats of a length=6 burst -> all outputs 0 immediately, no further beats; a new burst then runs cleanly.
REQ-039 MEM_STREAM_CSUM_EN defined, bytes 0xFF,0x02,0x10 -> csum=0x11 at done.
